// File: rtl/full_adder.sv
// full_adder: ripple-carry adder of 1-bit cells with combinational sum and registered status copy
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             ovf_q,
  output logic             zero_q
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic             ovf_d;
  logic             zero_d;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign carry_out = c[WIDTH];
  // next state: capture the adder result and flags when enabled, otherwise hold
  always_comb begin
    sum_d   = en ? sum : sum_q;
    carry_d = en ? c[WIDTH] : carry_q;
    ovf_d   = en ? c[WIDTH] ^ c[WIDTH-1] : ovf_q;
    zero_d  = en ? ~|sum : zero_q;
  end
  // registered outputs, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: table-driven and scoreboard checks of the ripple adder at WIDTH=1 and WIDTH=8
module tb_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a1, b1, ci1, en1;
  logic s1, co1, sq1, cq1, oq1, zq1;
  logic [7:0] a8, b8, s8, sq8;
  logic ci8, en8, co8, cq8, oq8, zq8;
  int pass_cnt = 0;
  int total = 0;
  typedef struct { logic a, b, ci, s, co; } v1_t;
  typedef struct { logic [7:0] a, b; logic ci, en; logic [7:0] s; logic co; } v8_t;
  typedef struct { logic [7:0] s; logic c, o, z; } exp_t;
  exp_t sb[$];
  exp_t m;
  v1_t t1[8];
  v8_t t8[5];
  always #5 clk = ~clk;
  full_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .cin(ci1), .en(en1),
    .sum(s1), .carry_out(co1), .sum_q(sq1), .carry_q(cq1), .ovf_q(oq1), .zero_q(zq1));
  full_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .cin(ci8), .en(en8),
    .sum(s8), .carry_out(co8), .sum_q(sq8), .carry_q(cq8), .ovf_q(oq8), .zero_q(zq8));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask
  task automatic cyc(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic en,
                     input bit full);
    logic [8:0] r;
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; ci8 = ci; en8 = en;
    r = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    #1;
    if (full) begin
      chk("sum", {24'd0, s8}, {24'd0, r[7:0]});
      chk("carry_out", {31'd0, co8}, {31'd0, r[8]});
    end else if ({co8, s8} !== r) chk("rand_comb", {23'd0, co8, s8}, {23'd0, r});
    if (en) begin
      m.s = r[7:0];
      m.c = r[8];
      m.o = (a[7] == b[7]) && (r[7] != a[7]);
      m.z = (r[7:0] == 8'd0);
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      if (full || {cq8, oq8, zq8, sq8} !== {e.c, e.o, e.z, e.s}) begin
        chk("sum_q", {24'd0, sq8}, {24'd0, e.s});
        chk("carry_q", {31'd0, cq8}, {31'd0, e.c});
        chk("ovf_q", {31'd0, oq8}, {31'd0, e.o});
        chk("zero_q", {31'd0, zq8}, {31'd0, e.z});
      end else begin
        total++;
        pass_cnt++;
      end
    end
  endtask
  initial begin
    t1[0] = '{0,0,0,0,0}; t1[1] = '{0,0,1,1,0}; t1[2] = '{0,1,0,1,0}; t1[3] = '{0,1,1,0,1};
    t1[4] = '{1,0,0,1,0}; t1[5] = '{1,0,1,0,1}; t1[6] = '{1,1,0,0,1}; t1[7] = '{1,1,1,1,1};
    t8[0] = '{8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1};
    t8[1] = '{8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0};
    t8[2] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1};
    t8[3] = '{8'h03, 8'h04, 1'b0, 1'b1, 8'h07, 1'b0};
    t8[4] = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0};
    m = '{8'd0, 1'b0, 1'b0, 1'b0};
    a1 = 0; b1 = 0; ci1 = 0; en1 = 0;
    a8 = 0; b8 = 0; ci8 = 0; en8 = 0;
    #3;
    chk("rst_sum_q", {24'd0, sq8}, 32'd0);
    chk("rst_flags", {29'd0, cq8, oq8, zq8}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      a1 = t1[i].a; b1 = t1[i].b; ci1 = t1[i].ci;
      #5;
      chk($sformatf("w1_sum_%0d", i), {31'd0, s1}, {31'd0, t1[i].s});
      chk($sformatf("w1_cout_%0d", i), {31'd0, co1}, {31'd0, t1[i].co});
    end
    @(negedge clk);
    rst = 1'b0;
    a1 = 1; b1 = 1; ci1 = 0; en1 = 1;
    @(posedge clk);
    #1;
    chk("w1_ovf_q", {31'd0, oq1}, 32'd1);
    chk("w1_carry_q", {31'd0, cq1}, 32'd1);
    en1 = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(t8[i].a, t8[i].b, t8[i].ci, t8[i].en, 1'b1);
      chk($sformatf("t8_sum_%0d", i), {24'd0, s8}, {24'd0, t8[i].s});
      chk($sformatf("t8_cout_%0d", i), {31'd0, co8}, {31'd0, t8[i].co});
    end
    chk("hold_sum_q", {24'd0, sq8}, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("async_sum_q", {24'd0, sq8}, 32'd0);
    chk("async_flags", {29'd0, cq8, oq8, zq8}, 32'd0);
    chk("async_comb_sum", {24'd0, s8}, 32'd2);
    m = '{8'd0, 1'b0, 1'b0, 1'b0};
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1200; i++)
      cyc(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
